// File: rtl/rs_br_param_if.sv
// Branch reservation station bus bundle.
//   disp_*   : two dispatch slots, packed slot-major (slot s at [s*W +: W])
//   cdb_*    : NCDB result buses snooped for missing operands
//   iss_*    : registered issue stage with valid/ready handshake
//   free_cnt : free entries, stall_BR : dispatch back-pressure
// master = dispatch/CDB/branch-unit side, slave = reservation station.
interface rs_br_param_if #(
  parameter int DEPTH  = 8,
  parameter int NCDB   = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int GHR_W  = 5
);
  logic [1:0]             disp_en;
  logic [1:0]             disp_v1;
  logic [1:0]             disp_v2;
  logic [2*TAG_W-1:0]     disp_tag1;
  logic [2*TAG_W-1:0]     disp_tag2;
  logic [2*TAG_W-1:0]     disp_dst_tag;
  logic [2*DATA_W-1:0]    disp_val1;
  logic [2*DATA_W-1:0]    disp_val2;
  logic [1:0]             disp_pred;
  logic [2*3-1:0]         disp_bcont;
  logic [2*GHR_W-1:0]     disp_ghr;
  logic [2*ADDR_W-1:0]    disp_next_addr;
  logic [2*ADDR_W-1:0]    disp_b_addr;
  logic [NCDB-1:0]        cdb_we;
  logic [NCDB*TAG_W-1:0]  cdb_tag;
  logic [NCDB*DATA_W-1:0] cdb_val;
  logic                   iss_valid;
  logic                   iss_ready;
  logic                   iss_pred;
  logic [2:0]             iss_bcont;
  logic [GHR_W-1:0]       iss_ghr;
  logic [TAG_W-1:0]       iss_dst_tag;
  logic [ADDR_W-1:0]      iss_next_addr;
  logic [ADDR_W-1:0]      iss_b_addr;
  logic [DATA_W-1:0]      iss_val1;
  logic [DATA_W-1:0]      iss_val2;
  logic [$clog2(DEPTH):0] free_cnt;
  logic                   stall_BR;

  modport master (
    output disp_en, disp_v1, disp_v2, disp_tag1, disp_tag2, disp_dst_tag,
           disp_val1, disp_val2, disp_pred, disp_bcont, disp_ghr,
           disp_next_addr, disp_b_addr, cdb_we, cdb_tag, cdb_val, iss_ready,
    input  iss_valid, iss_pred, iss_bcont, iss_ghr, iss_dst_tag,
           iss_next_addr, iss_b_addr, iss_val1, iss_val2, free_cnt, stall_BR
  );

  modport slave (
    input  disp_en, disp_v1, disp_v2, disp_tag1, disp_tag2, disp_dst_tag,
           disp_val1, disp_val2, disp_pred, disp_bcont, disp_ghr,
           disp_next_addr, disp_b_addr, cdb_we, cdb_tag, cdb_val, iss_ready,
    output iss_valid, iss_pred, iss_bcont, iss_ghr, iss_dst_tag,
           iss_next_addr, iss_b_addr, iss_val1, iss_val2, free_cnt, stall_BR
  );
endinterface

// File: rtl/rs_br_param.sv
// Branch reservation station: dual dispatch, CDB snoop with same-cycle
// bypass, oldest-ready select through a registered valid/ready issue stage.
//   clk   : clock
//   reset : asynchronous, active-low
//   flush : synchronous mispredict flush (empties entries and issue stage)
//   bus   : rs_br_param_if slave (dispatch, CDB, issue, free_cnt/stall_BR)
module rs_br_param #(
  parameter int DEPTH  = 8,
  parameter int NCDB   = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int GHR_W  = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  rs_br_param_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [DEPTH-1:0]  r_busy, r_v1, r_v2, r_pred;
  logic [TAG_W-1:0]  r_tag1  [DEPTH];
  logic [TAG_W-1:0]  r_tag2  [DEPTH];
  logic [TAG_W-1:0]  r_dst   [DEPTH];
  logic [DATA_W-1:0] r_val1  [DEPTH];
  logic [DATA_W-1:0] r_val2  [DEPTH];
  logic [2:0]        r_bcont [DEPTH];
  logic [GHR_W-1:0]  r_ghr   [DEPTH];
  logic [ADDR_W-1:0] r_next  [DEPTH];
  logic [ADDR_W-1:0] r_baddr [DEPTH];
  // r_age[i][j] = 1 : entry i is older than entry j
  logic [DEPTH-1:0]  r_age   [DEPTH];

  logic              r_iss_valid, r_iss_pred;
  logic [2:0]        r_iss_bcont;
  logic [GHR_W-1:0]  r_iss_ghr;
  logic [TAG_W-1:0]  r_iss_dst;
  logic [ADDR_W-1:0] r_iss_next, r_iss_baddr;
  logic [DATA_W-1:0] r_iss_val1, r_iss_val2;

  logic [DATA_W:0]   w_sn1 [DEPTH];
  logic [DATA_W:0]   w_sn2 [DEPTH];
  logic [DATA_W:0]   w_by1 [2];
  logic [DATA_W:0]   w_by2 [2];
  logic [DEPTH-1:0]  w_cand, w_blk;
  logic              w_sel_found, w_load, w_issue;
  logic [IW-1:0]     w_sel_idx, w_f0, w_f1;
  logic              w_f0_ok, w_f1_ok, w_stall;
  logic [CW-1:0]     w_free_cnt;
  logic [1:0]        w_alloc;
  logic [IW-1:0]     w_aidx  [2];
  logic [DEPTH-1:0]  w_older [2];

  // {hit, value}; the lowest-index matching bus wins
  function automatic logic [DATA_W:0] f_snoop(
    input logic [TAG_W-1:0]       tag,
    input logic [NCDB-1:0]        we,
    input logic [NCDB*TAG_W-1:0]  tags,
    input logic [NCDB*DATA_W-1:0] vals
  );
    logic [DATA_W:0] res;
    res = '0;
    for (int unsigned b = 0; b < NCDB; b++) begin
      if (!res[DATA_W] && we[b] && tags[b*TAG_W +: TAG_W] == tag)
        res = {1'b1, vals[b*DATA_W +: DATA_W]};
    end
    return res;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_sn1[i] = f_snoop(r_tag1[i], bus.cdb_we, bus.cdb_tag, bus.cdb_val);
      w_sn2[i] = f_snoop(r_tag2[i], bus.cdb_we, bus.cdb_tag, bus.cdb_val);
    end
    for (int unsigned s = 0; s < 2; s++) begin
      w_by1[s] = f_snoop(bus.disp_tag1[s*TAG_W +: TAG_W], bus.cdb_we, bus.cdb_tag, bus.cdb_val);
      w_by2[s] = f_snoop(bus.disp_tag2[s*TAG_W +: TAG_W], bus.cdb_we, bus.cdb_tag, bus.cdb_val);
    end
  end

  // Oldest ready: the candidate that no other candidate is older than
  assign w_cand = r_busy & r_v1 & r_v2;

  always_comb begin
    w_blk = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      for (int unsigned j = 0; j < DEPTH; j++)
        if (w_cand[j] && r_age[j][i]) w_blk[i] = 1'b1;
  end

  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (w_cand[i] && !w_blk[i]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    w_f0 = '0; w_f1 = '0; w_f0_ok = 1'b0; w_f1_ok = 1'b0;
    w_free_cnt = CW'(DEPTH);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_busy[i]) begin
        w_free_cnt = w_free_cnt - CW'(1);
      end else if (!w_f0_ok) begin
        w_f0 = IW'(i); w_f0_ok = 1'b1;
      end else if (!w_f1_ok) begin
        w_f1 = IW'(i); w_f1_ok = 1'b1;
      end
    end
  end

  assign w_stall    = (w_free_cnt < CW'(2));
  assign w_load     = !r_iss_valid || bus.iss_ready;
  assign w_issue    = w_load && w_sel_found;
  assign w_alloc[0] = bus.disp_en[0] && !w_stall && w_f0_ok;
  assign w_alloc[1] = bus.disp_en[1] && !w_stall && (bus.disp_en[0] ? w_f1_ok : w_f0_ok);
  assign w_aidx[0]  = w_f0;
  assign w_aidx[1]  = bus.disp_en[0] ? w_f1 : w_f0;
  // Entries left busy after this edge are older than slot 0; slot 0 is older than slot 1
  assign w_older[0] = r_busy & ~(w_issue ? (DEPTH'(1) << w_sel_idx) : '0);
  assign w_older[1] = w_older[0] | (w_alloc[0] ? (DEPTH'(1) << w_aidx[0]) : '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0; r_v1 <= '0; r_v2 <= '0; r_pred <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_tag1[i] <= '0; r_tag2[i] <= '0; r_dst[i] <= '0;
        r_val1[i] <= '0; r_val2[i] <= '0; r_bcont[i] <= '0;
        r_ghr[i] <= '0; r_next[i] <= '0; r_baddr[i] <= '0; r_age[i] <= '0;
      end
      r_iss_valid <= 1'b0; r_iss_pred <= 1'b0; r_iss_bcont <= '0;
      r_iss_ghr <= '0; r_iss_dst <= '0; r_iss_next <= '0; r_iss_baddr <= '0;
      r_iss_val1 <= '0; r_iss_val2 <= '0;
    end else if (flush) begin
      r_busy      <= '0;
      r_iss_valid <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (r_busy[i] && !r_v1[i] && w_sn1[i][DATA_W]) begin
          r_v1[i] <= 1'b1; r_val1[i] <= w_sn1[i][DATA_W-1:0];
        end
        if (r_busy[i] && !r_v2[i] && w_sn2[i][DATA_W]) begin
          r_v2[i] <= 1'b1; r_val2[i] <= w_sn2[i][DATA_W-1:0];
        end
      end
      if (w_load) begin
        r_iss_valid <= w_sel_found;
        if (w_sel_found) begin
          r_iss_pred  <= r_pred[w_sel_idx];  r_iss_bcont <= r_bcont[w_sel_idx];
          r_iss_ghr   <= r_ghr[w_sel_idx];   r_iss_dst   <= r_dst[w_sel_idx];
          r_iss_next  <= r_next[w_sel_idx];  r_iss_baddr <= r_baddr[w_sel_idx];
          r_iss_val1  <= r_val1[w_sel_idx];  r_iss_val2  <= r_val2[w_sel_idx];
          r_busy[w_sel_idx] <= 1'b0;
          r_age[w_sel_idx]  <= '0;
          for (int unsigned j = 0; j < DEPTH; j++) r_age[j][w_sel_idx] <= 1'b0;
        end
      end
      // Slot 0 always lands on the lower index, so slot 1's column write
      // into slot 0's row comes later in loop order and survives its row clear.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        for (int unsigned s = 0; s < 2; s++) begin
          if (w_alloc[s] && w_aidx[s] == IW'(i)) begin
            r_busy[i]  <= 1'b1;
            r_v1[i]    <= bus.disp_v1[s] | w_by1[s][DATA_W];
            r_v2[i]    <= bus.disp_v2[s] | w_by2[s][DATA_W];
            r_val1[i]  <= bus.disp_v1[s] ? bus.disp_val1[s*DATA_W +: DATA_W] : w_by1[s][DATA_W-1:0];
            r_val2[i]  <= bus.disp_v2[s] ? bus.disp_val2[s*DATA_W +: DATA_W] : w_by2[s][DATA_W-1:0];
            r_tag1[i]  <= bus.disp_tag1[s*TAG_W +: TAG_W];
            r_tag2[i]  <= bus.disp_tag2[s*TAG_W +: TAG_W];
            r_dst[i]   <= bus.disp_dst_tag[s*TAG_W +: TAG_W];
            r_pred[i]  <= bus.disp_pred[s];
            r_bcont[i] <= bus.disp_bcont[s*3 +: 3];
            r_ghr[i]   <= bus.disp_ghr[s*GHR_W +: GHR_W];
            r_next[i]  <= bus.disp_next_addr[s*ADDR_W +: ADDR_W];
            r_baddr[i] <= bus.disp_b_addr[s*ADDR_W +: ADDR_W];
            r_age[i]   <= '0;
            for (int unsigned j = 0; j < DEPTH; j++) r_age[j][i] <= w_older[s][j];
          end
        end
      end
    end
  end

  assign bus.iss_valid     = r_iss_valid;
  assign bus.iss_pred      = r_iss_pred;
  assign bus.iss_bcont     = r_iss_bcont;
  assign bus.iss_ghr       = r_iss_ghr;
  assign bus.iss_dst_tag   = r_iss_dst;
  assign bus.iss_next_addr = r_iss_next;
  assign bus.iss_b_addr    = r_iss_baddr;
  assign bus.iss_val1      = r_iss_val1;
  assign bus.iss_val2      = r_iss_val2;
  assign bus.free_cnt      = w_free_cnt;
  assign bus.stall_BR      = w_stall;
endmodule

// File: tb/tb_rs_br_param.sv
// Bench for rs_br_param: directed scenarios plus random traffic, all checked
// against an in-order queue model of the reservation station.
module tb_rs_br_param;
  localparam int DEPTH = 8, NCDB = 4, TAG_W = 5, DATA_W = 32, ADDR_W = 8, GHR_W = 5;

  logic clk = 1'b0, rst_n = 1'b1, flush = 1'b0;
  always #5 clk = ~clk;

  rs_br_param_if #(.DEPTH(DEPTH), .NCDB(NCDB), .TAG_W(TAG_W), .DATA_W(DATA_W),
                   .ADDR_W(ADDR_W), .GHR_W(GHR_W)) bus ();

  rs_br_param #(.DEPTH(DEPTH), .NCDB(NCDB), .TAG_W(TAG_W), .DATA_W(DATA_W),
                .ADDR_W(ADDR_W), .GHR_W(GHR_W)) u_dut (
    .clk(clk), .reset(rst_n), .flush(flush), .bus(bus)
  );

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic v1, v2;
    logic [TAG_W-1:0] t1, t2, dst;
    logic [DATA_W-1:0] d1, d2;
    logic pred;
    logic [2:0] bc;
    logic [GHR_W-1:0] ghr;
    logic [ADDR_W-1:0] na, ba;
  } ent_t;

  // Model: queue in dispatch order, so the oldest ready entry is the first ready one
  ent_t q[$];
  ent_t m_out = '0;
  bit   m_valid = 1'b0;

  function automatic logic [DATA_W:0] cdb_lookup(input logic [TAG_W-1:0] t);
    for (int b = 0; b < NCDB; b++)
      if (bus.cdb_we[b] && bus.cdb_tag[b*TAG_W +: TAG_W] == t)
        return {1'b1, bus.cdb_val[b*DATA_W +: DATA_W]};
    return '0;
  endfunction

  task automatic m_reset();
    q.delete(); m_valid = 1'b0; m_out = '0;
  endtask

  task automatic m_step();
    logic [DATA_W:0] h;
    ent_t e;
    int pick;
    bit stall;
    if (!rst_n) begin m_reset(); return; end
    if (flush)  begin q.delete(); m_valid = 1'b0; return; end
    stall = (DEPTH - q.size()) < 2;
    if (!m_valid || bus.iss_ready) begin
      pick = -1;
      foreach (q[i]) if (pick < 0 && q[i].v1 && q[i].v2) pick = i;
      if (pick >= 0) begin m_out = q[pick]; q.delete(pick); m_valid = 1'b1; end
      else m_valid = 1'b0;
    end
    foreach (q[i]) begin
      if (!q[i].v1) begin h = cdb_lookup(q[i].t1); if (h[DATA_W]) begin q[i].v1 = 1'b1; q[i].d1 = h[DATA_W-1:0]; end end
      if (!q[i].v2) begin h = cdb_lookup(q[i].t2); if (h[DATA_W]) begin q[i].v2 = 1'b1; q[i].d2 = h[DATA_W-1:0]; end end
    end
    if (!stall) begin
      for (int s = 0; s < 2; s++) begin
        if (bus.disp_en[s]) begin
          e.v1 = bus.disp_v1[s]; e.v2 = bus.disp_v2[s];
          e.t1 = bus.disp_tag1[s*TAG_W +: TAG_W]; e.t2 = bus.disp_tag2[s*TAG_W +: TAG_W];
          e.dst = bus.disp_dst_tag[s*TAG_W +: TAG_W];
          e.d1 = bus.disp_val1[s*DATA_W +: DATA_W]; e.d2 = bus.disp_val2[s*DATA_W +: DATA_W];
          e.pred = bus.disp_pred[s]; e.bc = bus.disp_bcont[s*3 +: 3];
          e.ghr = bus.disp_ghr[s*GHR_W +: GHR_W];
          e.na = bus.disp_next_addr[s*ADDR_W +: ADDR_W]; e.ba = bus.disp_b_addr[s*ADDR_W +: ADDR_W];
          if (!e.v1) begin h = cdb_lookup(e.t1); if (h[DATA_W]) begin e.v1 = 1'b1; e.d1 = h[DATA_W-1:0]; end end
          if (!e.v2) begin h = cdb_lookup(e.t2); if (h[DATA_W]) begin e.v2 = 1'b1; e.d2 = h[DATA_W-1:0]; end end
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic compare();
    chk("iss_valid", 64'(bus.iss_valid), 64'(m_valid));
    chk("free_cnt", 64'(bus.free_cnt), 64'(DEPTH - q.size()));
    chk("stall_BR", 64'(bus.stall_BR), 64'((DEPTH - q.size()) < 2));
    if (m_valid) begin
      chk("iss_val1", 64'(bus.iss_val1), 64'(m_out.d1));
      chk("iss_val2", 64'(bus.iss_val2), 64'(m_out.d2));
      chk("iss_b_addr", 64'(bus.iss_b_addr), 64'(m_out.ba));
      chk("iss_next_addr", 64'(bus.iss_next_addr), 64'(m_out.na));
      chk("iss_misc", 64'({bus.iss_pred, bus.iss_bcont, bus.iss_ghr, bus.iss_dst_tag}),
          64'({m_out.pred, m_out.bc, m_out.ghr, m_out.dst}));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
    compare();
  endtask

  task automatic idle();
    bus.disp_en = '0; bus.cdb_we = '0; flush = 1'b0;
  endtask

  task automatic slot(input int s, input logic v1, input logic v2,
                      input logic [TAG_W-1:0] t1, input logic [TAG_W-1:0] t2,
                      input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2,
                      input logic [ADDR_W-1:0] ba);
    bus.disp_en[s] = 1'b1; bus.disp_v1[s] = v1; bus.disp_v2[s] = v2;
    bus.disp_tag1[s*TAG_W +: TAG_W] = t1; bus.disp_tag2[s*TAG_W +: TAG_W] = t2;
    bus.disp_val1[s*DATA_W +: DATA_W] = d1; bus.disp_val2[s*DATA_W +: DATA_W] = d2;
    bus.disp_b_addr[s*ADDR_W +: ADDR_W] = ba;
    bus.disp_next_addr[s*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
    bus.disp_dst_tag[s*TAG_W +: TAG_W] = TAG_W'($urandom);
    bus.disp_pred[s] = 1'($urandom);
    bus.disp_bcont[s*3 +: 3] = 3'($urandom);
    bus.disp_ghr[s*GHR_W +: GHR_W] = GHR_W'($urandom);
  endtask

  task automatic cdb(input int b, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v);
    bus.cdb_we[b] = 1'b1;
    bus.cdb_tag[b*TAG_W +: TAG_W] = t;
    bus.cdb_val[b*DATA_W +: DATA_W] = v;
  endtask

  initial begin
    bus.disp_en = '0; bus.disp_v1 = '0; bus.disp_v2 = '0; bus.disp_tag1 = '0;
    bus.disp_tag2 = '0; bus.disp_dst_tag = '0; bus.disp_val1 = '0; bus.disp_val2 = '0;
    bus.disp_pred = '0; bus.disp_bcont = '0; bus.disp_ghr = '0; bus.disp_next_addr = '0;
    bus.disp_b_addr = '0; bus.cdb_we = '0; bus.cdb_tag = '0; bus.cdb_val = '0;
    bus.iss_ready = 1'b1;

    // Reset and idle
    #2 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst_valid", 64'(bus.iss_valid), 64'd0);
    chk("rst_free", 64'(bus.free_cnt), 64'd8);
    chk("rst_stall", 64'(bus.stall_BR), 64'd0);
    chk("rst_b_addr", 64'(bus.iss_b_addr), 64'd0);
    tick();

    // Dual dispatch, both ready
    slot(0, 1, 1, 0, 0, 32'h11, 32'h12, 8'h10);
    slot(1, 1, 1, 0, 0, 32'h21, 32'h22, 8'h20);
    tick(); idle();
    tick();
    chk("dual_valid", 64'(bus.iss_valid), 64'd1);
    chk("dual_first", 64'(bus.iss_b_addr), 64'h10);
    tick();
    chk("dual_second", 64'(bus.iss_b_addr), 64'h20);
    chk("dual_free", 64'(bus.free_cnt), 64'd8);
    tick();

    // Wakeup and age ordering
    slot(0, 0, 1, 3, 0, 32'h0, 32'h1, 8'hA0);
    tick(); idle();
    slot(0, 1, 1, 0, 0, 32'h5, 32'h6, 8'hB0);
    tick(); idle();
    tick();
    chk("age_B_first", 64'(bus.iss_b_addr), 64'hB0);
    cdb(2, 3, 32'hDEAD);
    tick(); idle();
    tick();
    chk("wake_A", 64'(bus.iss_b_addr), 64'hA0);
    chk("wake_val1", 64'(bus.iss_val1), 64'hDEAD);
    tick();

    // Same-cycle bypass
    slot(0, 1, 0, 0, 7, 32'h9, 32'h0, 8'hC0);
    cdb(0, 7, 32'd5);
    tick(); idle();
    tick();
    chk("bypass_valid", 64'(bus.iss_valid), 64'd1);
    chk("bypass_val2", 64'(bus.iss_val2), 64'd5);
    tick();

    // Full / back-pressure
    bus.iss_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      idle();
      slot(0, 1, 1, 0, 0, $urandom, $urandom, ADDR_W'(8'h40 + k));
      tick();
    end
    chk("full_stall", 64'(bus.stall_BR), 64'd1);
    chk("full_free", 64'(bus.free_cnt), 64'd1);
    slot(1, 1, 1, 0, 0, 32'h1, 32'h2, 8'hEE);
    repeat (3) tick();
    chk("hold_b_addr", 64'(bus.iss_b_addr), 64'h40);
    idle();
    bus.iss_ready = 1'b1;
    repeat (9) tick();
    chk("drain_free", 64'(bus.free_cnt), 64'd8);

    // Flush with 5 busy entries and a held issue
    bus.iss_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idle();
      slot(0, 1, 1, 0, 0, $urandom, $urandom, ADDR_W'(8'h60 + 2*k));
      slot(1, 1, 1, 0, 0, $urandom, $urandom, ADDR_W'(8'h61 + 2*k));
      tick();
    end
    chk("preflush_free", 64'(bus.free_cnt), 64'd3);
    chk("preflush_valid", 64'(bus.iss_valid), 64'd1);
    flush = 1'b1;
    cdb(1, 0, 32'h77);
    tick(); idle();
    chk("flush_free", 64'(bus.free_cnt), 64'd8);
    chk("flush_valid", 64'(bus.iss_valid), 64'd0);
    bus.iss_ready = 1'b1;
    tick();

    // Asynchronous reset between edges, mid-dispatch and mid-issue
    slot(0, 1, 1, 0, 0, 32'h31, 32'h32, 8'h70);
    slot(1, 1, 1, 0, 0, 32'h41, 32'h42, 8'h71);
    tick(); idle();
    tick();
    slot(0, 1, 1, 0, 0, 32'h51, 32'h52, 8'h72);
    #3 rst_n = 1'b0;
    #1;
    m_reset();
    chk("arst_valid", 64'(bus.iss_valid), 64'd0);
    chk("arst_free", 64'(bus.free_cnt), 64'd8);
    chk("arst_stall", 64'(bus.stall_BR), 64'd0);
    chk("arst_b_addr", 64'(bus.iss_b_addr), 64'd0);
    chk("arst_val1", 64'(bus.iss_val1), 64'd0);
    tick();
    rst_n = 1'b1;
    idle();
    tick();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      idle();
      for (int s = 0; s < 2; s++)
        if ($urandom_range(0, 1) == 1)
          slot(s, ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0),
               TAG_W'($urandom_range(0, 7)), TAG_W'($urandom_range(0, 7)),
               $urandom, $urandom, ADDR_W'($urandom));
      for (int b = 0; b < NCDB; b++)
        if ($urandom_range(0, 1) == 1) cdb(b, TAG_W'($urandom_range(0, 7)), $urandom);
      bus.iss_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 59) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
